// File: rtl/i_decoder_pkg.sv
// Shared decode constants and the control-word layout for the MIPS-style
// instruction decoder.
package i_decoder_pkg;

    // Primary opcodes, instruction[31:26]
    localparam logic [5:0] OP_RTYPE     = 6'b000000;
    localparam logic [5:0] OP_BLTZ      = 6'b000001;
    localparam logic [5:0] OP_J         = 6'b000010;
    localparam logic [5:0] OP_JAL       = 6'b000011;
    localparam logic [5:0] OP_BEQ       = 6'b000100;
    localparam logic [5:0] OP_BNE       = 6'b000101;
    localparam logic [5:0] OP_BLEZ      = 6'b000110;
    localparam logic [5:0] OP_BGTZ_BGEZ = 6'b000111;
    localparam logic [5:0] OP_ADDI      = 6'b001000;
    localparam logic [5:0] OP_ADDIU     = 6'b001001;
    localparam logic [5:0] OP_SLTIU     = 6'b001011;
    localparam logic [5:0] OP_ORI       = 6'b001101;
    localparam logic [5:0] OP_XORI      = 6'b001110;
    localparam logic [5:0] OP_LUI       = 6'b001111;
    localparam logic [5:0] OP_LW        = 6'b100011;
    localparam logic [5:0] OP_SW        = 6'b101011;

    // R-type function codes, instruction[5:0]
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_ADD  = 6'b010000;
    localparam logic [5:0] F_ADDU = 6'b010001;
    localparam logic [5:0] F_SUB  = 6'b010010;
    localparam logic [5:0] F_SUBU = 6'b010011;
    localparam logic [5:0] F_AND  = 6'b010100;
    localparam logic [5:0] F_OR   = 6'b010101;
    localparam logic [5:0] F_XOR  = 6'b010110;
    localparam logic [5:0] F_NOR  = 6'b010111;
    localparam logic [5:0] F_SLT  = 6'b011010;
    localparam logic [5:0] F_SLTU = 6'b011011;

    typedef enum logic [3:0] {
        AF_ADD  = 4'b0000,
        AF_ADDU = 4'b0001,
        AF_SUB  = 4'b0010,
        AF_SUBU = 4'b0011,
        AF_AND  = 4'b0100,
        AF_OR   = 4'b0101,
        AF_XOR  = 4'b0110,
        AF_NOR  = 4'b0111,
        AF_SLT  = 4'b1010,
        AF_SLTU = 4'b1011,
        AF_LUI  = 4'b1100
    } af_t;

    typedef enum logic [3:0] {
        BF_NONE = 4'b0000,
        BF_BEQ  = 4'b0001,
        BF_BNE  = 4'b0010,
        BF_BLEZ = 4'b0011,
        BF_BGTZ = 4'b0100,
        BF_BLTZ = 4'b0101,
        BF_BGEZ = 4'b0110
    } bf_t;

    // Bit 2 set means the shift amount is taken from rs instead of shamt.
    typedef enum logic [2:0] {
        SH_NONE = 3'b000,
        SH_SLL  = 3'b001,
        SH_SRL  = 3'b010,
        SH_SRA  = 3'b011,
        SH_SLLV = 3'b101,
        SH_SRLV = 3'b110,
        SH_SRAV = 3'b111
    } shift_t;

    typedef enum logic [1:0] {
        GP_ALU   = 2'b00,
        GP_MEM   = 2'b01,
        GP_LINK  = 2'b10,
        GP_SHIFT = 2'b11
    } gp_mux_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_RS     = 2'b11
    } pc_mux_t;

    typedef struct packed {
        af_t         af;
        logic        i;
        logic        alu_mux_sel;
        logic [4:0]  cad;
        logic        gp_we;
        gp_mux_t     gp_mux_sel;
        bf_t         bf;
        logic        dm_we;
        shift_t      shift_type;
        pc_mux_t     pc_mux_select;
    } ctrl_word_t;

    localparam int CTRL_W = $bits(ctrl_word_t);

    // A destination address is only meaningful when the register file is
    // written; keep it at zero otherwise so downstream hazard logic never
    // sees a phantom destination.
    function automatic ctrl_word_t mask_dest(ctrl_word_t w);
        ctrl_word_t r;
        r = w;
        if (!r.gp_we) begin
            r.cad = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/i_decoder_comb.sv
// Purely combinational instruction decode producing the packed control word.
module i_decoder_comb
    import i_decoder_pkg::*;
#(
    parameter logic [4:0] LINK_REG = 5'd31
) (
    input  logic [31:0]       instruction,
    output logic [CTRL_W-1:0] ctrl
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_fields;

    assign op    = instruction[31:26];
    assign rt    = instruction[20:16];
    assign rd    = instruction[15:11];
    assign funct = instruction[5:0];

    // rs and shamt feed the datapath directly; the decoder never looks at them.
    assign unused_fields = ^{instruction[25:21], instruction[10:6]};

    // Decode the opcode/funct into a control word; unknown encodings stay NOP.
    always_comb begin
        ctrl_word_t w;
        logic       r_write;
        w       = '0;
        r_write = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU, F_SUB, F_SUBU,
                    F_AND, F_OR, F_XOR, F_NOR,
                    F_SLT, F_SLTU: begin
                        w.af         = af_t'(funct[3:0]);
                        w.gp_mux_sel = GP_ALU;
                        r_write      = 1'b1;
                    end
                    F_SLL:   w.shift_type = SH_SLL;
                    F_SRL:   w.shift_type = SH_SRL;
                    F_SRA:   w.shift_type = SH_SRA;
                    F_SLLV:  w.shift_type = SH_SLLV;
                    F_SRLV:  w.shift_type = SH_SRLV;
                    F_SRAV:  w.shift_type = SH_SRAV;
                    F_JR:    w.pc_mux_select = PC_RS;
                    default: ;
                endcase
                if (w.shift_type != SH_NONE) begin
                    w.gp_mux_sel = GP_SHIFT;
                    r_write      = 1'b1;
                end
                if (r_write) begin
                    w.cad   = rd;
                    w.gp_we = 1'b1;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTIU, OP_ORI, OP_XORI, OP_LUI: begin
                w.i           = 1'b1;
                w.alu_mux_sel = 1'b1;
                w.cad         = rt;
                w.gp_we       = 1'b1;
                w.gp_mux_sel  = GP_ALU;
                case (op)
                    OP_ADDIU: w.af = AF_ADDU;
                    OP_SLTIU: w.af = AF_SLTU;
                    OP_ORI:   w.af = AF_OR;
                    OP_XORI:  w.af = AF_XOR;
                    OP_LUI:   w.af = AF_LUI;
                    default:  w.af = AF_ADD;
                endcase
            end
            OP_LW: begin
                w.i           = 1'b1;
                w.alu_mux_sel = 1'b1;
                w.af          = AF_ADDU;
                w.cad         = rt;
                w.gp_we       = 1'b1;
                w.gp_mux_sel  = GP_MEM;
            end
            OP_SW: begin
                w.i           = 1'b1;
                w.alu_mux_sel = 1'b1;
                w.af          = AF_ADDU;
                w.dm_we       = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BLTZ, OP_BGTZ_BGEZ: begin
                w.i             = 1'b1;
                w.af            = AF_SUB;
                w.pc_mux_select = PC_BRANCH;
                case (op)
                    OP_BEQ:  w.bf = BF_BEQ;
                    OP_BNE:  w.bf = BF_BNE;
                    OP_BLEZ: w.bf = BF_BLEZ;
                    OP_BLTZ: w.bf = BF_BLTZ;
                    default: w.bf = rt[1] ? BF_BGTZ : BF_BGEZ;
                endcase
            end
            OP_J: begin
                w.pc_mux_select = PC_JUMP;
            end
            OP_JAL: begin
                w.pc_mux_select = PC_JUMP;
                w.cad           = LINK_REG;
                w.gp_we         = 1'b1;
                w.gp_mux_sel    = GP_LINK;
            end
            default: ;
        endcase
        ctrl = mask_dest(w);
    end

endmodule

// File: rtl/i_decoder.sv
// Registered instruction decoder: combinational decode followed by an
// async-reset output register (one cycle latency, NOP word under reset).
module i_decoder
    import i_decoder_pkg::*;
#(
    parameter logic [4:0] LINK_REG = 5'd31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    output logic [3:0]  Af,
    output logic        I,
    output logic        ALU_MUX_SEL,
    output logic [4:0]  Cad,
    output logic        GP_WE,
    output logic [1:0]  GP_MUX_SEL,
    output logic [3:0]  Bf,
    output logic        DM_WE,
    output logic [2:0]  Shift_type,
    output logic [1:0]  PC_MUX_Select
);

    logic [CTRL_W-1:0] ctrl_next;
    ctrl_word_t        ctrl_q;

    i_decoder_comb #(
        .LINK_REG (LINK_REG)
    ) u_comb (
        .instruction (instruction),
        .ctrl        (ctrl_next)
    );

    // Capture the decoded word each cycle; reset forces an all-zero NOP word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_word_t'(ctrl_next);
        end
    end

    assign Af            = ctrl_q.af;
    assign I             = ctrl_q.i;
    assign ALU_MUX_SEL   = ctrl_q.alu_mux_sel;
    assign Cad           = ctrl_q.cad;
    assign GP_WE         = ctrl_q.gp_we;
    assign GP_MUX_SEL    = ctrl_q.gp_mux_sel;
    assign Bf            = ctrl_q.bf;
    assign DM_WE         = ctrl_q.dm_we;
    assign Shift_type    = ctrl_q.shift_type;
    assign PC_MUX_Select = ctrl_q.pc_mux_select;

endmodule

// File: tb/tb_i_decoder.sv
// Scoreboard bench for i_decoder: stimulus pushes expected control words from
// a table-driven reference model; a monitor pops and compares one cycle later.
module tb_i_decoder;

    typedef struct packed {
        logic [3:0] af;
        logic       i;
        logic       alu;
        logic [4:0] cad;
        logic       gp_we;
        logic [1:0] gp_mux;
        logic [3:0] bf;
        logic       dm_we;
        logic [2:0] shift;
        logic [1:0] pc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic [3:0]  Af;
    logic        I;
    logic        ALU_MUX_SEL;
    logic [4:0]  Cad;
    logic        GP_WE;
    logic [1:0]  GP_MUX_SEL;
    logic [3:0]  Bf;
    logic        DM_WE;
    logic [2:0]  Shift_type;
    logic [1:0]  PC_MUX_Select;

    int errors = 0;
    int checks = 0;

    exp_t        exp_q [$];
    logic [31:0] ins_q [$];

    // Reference tables taken straight from the instruction set description.
    logic [3:0] r_alu_af  [int];
    logic [2:0] r_shift   [int];
    logic [3:0] i_alu_af  [int];
    logic [3:0] branch_bf [int];
    int         known_ops [$];

    i_decoder #(.LINK_REG(5'd31)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instruction   (instruction),
        .Af            (Af),
        .I             (I),
        .ALU_MUX_SEL   (ALU_MUX_SEL),
        .Cad           (Cad),
        .GP_WE         (GP_WE),
        .GP_MUX_SEL    (GP_MUX_SEL),
        .Bf            (Bf),
        .DM_WE         (DM_WE),
        .Shift_type    (Shift_type),
        .PC_MUX_Select (PC_MUX_Select)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(logic [31:0] ins);
        exp_t e;
        int   op;
        int   fn;
        e  = '0;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        if (op == 0) begin
            if (r_alu_af.exists(fn)) begin
                e.af = r_alu_af[fn]; e.gp_we = 1'b1; e.cad = ins[15:11];
            end else if (r_shift.exists(fn)) begin
                e.shift = r_shift[fn]; e.gp_mux = 2'b11; e.gp_we = 1'b1; e.cad = ins[15:11];
            end else if (fn == 8) begin
                e.pc = 2'b11;
            end
        end else if (i_alu_af.exists(op)) begin
            e.i = 1'b1; e.alu = 1'b1; e.af = i_alu_af[op]; e.cad = ins[20:16]; e.gp_we = 1'b1;
        end else if (op == 35) begin
            e.i = 1'b1; e.alu = 1'b1; e.af = 4'd1; e.cad = ins[20:16]; e.gp_we = 1'b1; e.gp_mux = 2'b01;
        end else if (op == 43) begin
            e.i = 1'b1; e.alu = 1'b1; e.af = 4'd1; e.dm_we = 1'b1;
        end else if (branch_bf.exists(op) || op == 7) begin
            e.i = 1'b1; e.af = 4'd2; e.pc = 2'b01;
            if (op == 7) e.bf = ins[17] ? 4'd4 : 4'd6;
            else         e.bf = branch_bf[op];
        end else if (op == 2) begin
            e.pc = 2'b10;
        end else if (op == 3) begin
            e.pc = 2'b10; e.cad = 5'd31; e.gp_we = 1'b1; e.gp_mux = 2'b10;
        end
        return e;
    endfunction

    function automatic exp_t dut_word();
        exp_t a;
        a = {Af, I, ALU_MUX_SEL, Cad, GP_WE, GP_MUX_SEL, Bf, DM_WE, Shift_type, PC_MUX_Select};
        return a;
    endfunction

    task automatic check_zero(input string name);
        exp_t a;
        a = dut_word();
        checks++;
        if (a !== '0) begin
            errors++;
            $display("FAIL %s got=%06h want=000000", name, a);
        end
    endtask

    task automatic issue(input logic [31:0] ins);
        @(negedge clk);
        instruction = ins;
        exp_q.push_back(model(ins));
        ins_q.push_back(ins);
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 3);
        case (k)
            1: begin
                r[31:26] = 6'd0;
                if ($urandom_range(0, 3) != 0) begin
                    r[5:0] = 6'($urandom_range(0, 27));
                end
            end
            2: r[31:26] = 6'(known_ops[$urandom_range(0, known_ops.size() - 1)]);
            3: r[31:26] = ($urandom_range(0, 1) == 1) ? 6'd7 : 6'd1;
            default: ;
        endcase
        return r;
    endfunction

    // Monitor: the DUT presents a new word after every rising edge out of reset.
    always @(posedge clk) begin
        exp_t        e;
        exp_t        a;
        logic [31:0] ins;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            ins = ins_q.pop_front();
            a   = dut_word();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL ctrl instr=%08h got=%06h want=%06h", ins, a, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        r_alu_af[16] = 4'd0;  r_alu_af[17] = 4'd1;  r_alu_af[18] = 4'd2;  r_alu_af[19] = 4'd3;
        r_alu_af[20] = 4'd4;  r_alu_af[21] = 4'd5;  r_alu_af[22] = 4'd6;  r_alu_af[23] = 4'd7;
        r_alu_af[26] = 4'd10; r_alu_af[27] = 4'd11;
        r_shift[0] = 3'd1; r_shift[2] = 3'd2; r_shift[3] = 3'd3;
        r_shift[4] = 3'd5; r_shift[6] = 3'd6; r_shift[7] = 3'd7;
        i_alu_af[8] = 4'd0;  i_alu_af[9] = 4'd1;  i_alu_af[11] = 4'd11;
        i_alu_af[13] = 4'd5; i_alu_af[14] = 4'd6; i_alu_af[15] = 4'd12;
        branch_bf[4] = 4'd1; branch_bf[5] = 4'd2; branch_bf[6] = 4'd3; branch_bf[1] = 4'd5;
        known_ops = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 11, 13, 14, 15, 35, 43};

        // Asynchronous reset with an LW waiting on the input.
        instruction = 32'h8C01_0000;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_zero("reset_async");
        repeat (2) @(negedge clk);
        check_zero("reset_hold");

        // Release: the LW already on the bus is the first captured word.
        rst_n = 1'b1;
        exp_q.push_back(model(instruction));
        ins_q.push_back(instruction);

        foreach (directed[n]) issue(directed[n]);
        repeat (300) issue(rand_ins());

        // Mid-stream reset lands between edges and must clear the outputs at once.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero("reset_midstream");
        @(negedge clk);
        instruction = 32'h0C00_0001;
        @(posedge clk);
        #1 check_zero("reset_midstream_hold");
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(model(instruction));
        ins_q.push_back(instruction);
        repeat (20) issue(rand_ins());

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    logic [31:0] directed [18] = '{
        32'h2022_0001, // ADDI
        32'h3C22_0001, // LUI
        32'h1022_0001, // BEQ
        32'h1C21_0000, // BGEZ
        32'h1C22_0001, // BGTZ
        32'h0421_0000, // BLTZ
        32'h0021_1010, // ADD
        32'h0021_101B, // SLTU
        32'h0021_1007, // SRAV
        32'h0021_1000, // SLL
        32'h0C00_0001, // JAL
        32'h0800_0001, // J
        32'hFC21_1010, // illegal opcode
        32'h0021_103F, // illegal funct
        32'hAC22_0004, // SW
        32'h03E0_0008, // JR
        32'h3822_00FF, // XORI
        32'h0000_0000  // NOP (SLL r0)
    };

endmodule
